// File: rtl/oam_access_ctrl_if.sv
// CPU-side bus for the FE00-FEFF OAM window.
// master = CPU bus decoder, slave = oam_access_ctrl.
interface oam_access_ctrl_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_rvalid;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_rvalid
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_rvalid
  );
endinterface

// File: rtl/oam_access_ctrl.sv
// OAM port owner: OAM DMA sequencer plus fixed-priority arbitration
// DMA > PPU > CPU, with Game Boy CPU lockout during DMA and PPU modes 2/3.
// Optional build macro OAM_DMA_ECHO_MIRROR_EN: DMA source pages E0-FF are
// folded onto C0-DF (echo RAM) when the page is latched.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | no transfer; OAM port free for PPU/CPU
// DELAY | start-up wait after dma_start, port already reserved
// RD    | source bus read of byte idx
// WR    | OAM write of byte idx with the returned source data
module oam_access_ctrl #(
  parameter int unsigned OAM_BYTES   = 160,
  parameter int unsigned START_DELAY = 4
) (
  input  logic               clk,
  input  logic               reset,
  oam_access_ctrl_if.slave   cpu,
  input  logic [1:0]         ppu_mode,
  input  logic               ppu_req,
  input  logic [7:0]         ppu_addr,
  output logic [7:0]         ppu_rdata,
  output logic               ppu_rvalid,
  input  logic               dma_start,
  input  logic [7:0]         dma_src_hi,
  output logic               dma_bus_req,
  output logic [15:0]        dma_bus_addr,
  input  logic [7:0]         dma_bus_rdata,
  output logic               dma_active,
  output logic               oam_en,
  output logic               oam_we,
  output logic [7:0]         oam_addr,
  output logic [7:0]         oam_din,
  input  logic [7:0]         oam_dout
);

  localparam int unsigned    DW       = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DW-1:0]  DLY_LOAD = DW'(START_DELAY - 1);
  localparam logic [7:0]     LAST_IDX = 8'(OAM_BYTES - 1);
  localparam logic [8:0]     OAM_LIM  = 9'(OAM_BYTES);

  typedef enum logic [1:0] {IDLE, DELAY, RD, WR} state_t;
  // Who the registered read data belongs to in the following cycle.
  typedef enum logic [1:0] {RSEL_NONE, RSEL_OAM, RSEL_FF, RSEL_ZERO} rsel_t;

  state_t         state, state_nxt;
  logic [7:0]     idx, idx_nxt;
  logic [DW-1:0]  cnt, cnt_nxt;
  logic [7:0]     src_hi, src_nxt;
  logic           dma_wr;
  logic           ppu_win;
  logic           cpu_blocked;
  logic           cpu_in_range;
  rsel_t          cpu_sel, cpu_sel_nxt;
  rsel_t          ppu_sel, ppu_sel_nxt;

  function automatic logic [7:0] map_src(input logic [7:0] page);
`ifdef OAM_DMA_ECHO_MIRROR_EN
    return (page >= 8'hE0) ? (page - 8'h20) : page;
`else
    return page;
`endif
  endfunction

  // DMA state, byte index, start-delay timer and latched source page.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= 8'h00;
      cnt    <= '0;
      src_hi <= 8'h00;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      src_hi <= src_nxt;
    end
  end

  // DMA next state and source-bus outputs; dma_start restarts from any state.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    cnt_nxt      = cnt;
    src_nxt      = src_hi;
    dma_bus_req  = 1'b0;
    dma_bus_addr = 16'h0000;
    dma_wr       = 1'b0;
    case (state)
      IDLE: ;
      DELAY: begin
        if (cnt == '0) state_nxt = RD;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RD: begin
        dma_bus_req  = ~reset;
        dma_bus_addr = reset ? 16'h0000 : {src_hi, idx};
        state_nxt    = WR;
      end
      WR: begin
        dma_wr = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx + 8'd1;
          state_nxt = RD;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (dma_start) begin
      state_nxt = DELAY;
      idx_nxt   = 8'h00;
      cnt_nxt   = DLY_LOAD;
      src_nxt   = map_src(dma_src_hi);
    end
  end

  assign dma_active   = (state != IDLE);
  assign ppu_win      = ppu_req && !dma_active;
  assign cpu_blocked  = dma_active || (ppu_mode >= 2'd2) || ppu_req;
  assign cpu_in_range = ({1'b0, cpu.cpu_addr} < OAM_LIM);

  // OAM port arbitration and next-cycle read-data ownership.
  always_comb begin
    oam_en      = 1'b0;
    oam_we      = 1'b0;
    oam_addr    = 8'h00;
    oam_din     = 8'h00;
    cpu_sel_nxt = RSEL_NONE;
    ppu_sel_nxt = RSEL_NONE;
    if (dma_wr) begin
      oam_en   = 1'b1;
      oam_we   = 1'b1;
      oam_addr = idx;
      oam_din  = dma_bus_rdata;
    end else if (ppu_win) begin
      oam_en   = 1'b1;
      oam_addr = ppu_addr;
    end else if (cpu.cpu_req && !cpu_blocked && cpu_in_range) begin
      oam_en   = 1'b1;
      oam_we   = cpu.cpu_we;
      oam_addr = cpu.cpu_addr;
      oam_din  = cpu.cpu_we ? cpu.cpu_wdata : 8'h00;
    end
    if (ppu_req) ppu_sel_nxt = dma_active ? RSEL_FF : RSEL_OAM;
    if (cpu.cpu_req && !cpu.cpu_we) begin
      if (cpu_blocked)        cpu_sel_nxt = RSEL_FF;
      else if (!cpu_in_range) cpu_sel_nxt = RSEL_ZERO;
      else                    cpu_sel_nxt = RSEL_OAM;
    end
    // A reset in the middle of a transfer must not let the pending write land.
    if (reset) begin
      oam_en   = 1'b0;
      oam_we   = 1'b0;
      oam_addr = 8'h00;
      oam_din  = 8'h00;
    end
  end

  // Last-reader tags: oam_dout is forwarded only to the requester that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_sel <= RSEL_NONE;
      ppu_sel <= RSEL_NONE;
    end else begin
      cpu_sel <= cpu_sel_nxt;
      ppu_sel <= ppu_sel_nxt;
    end
  end

  assign cpu.cpu_rvalid = (cpu_sel != RSEL_NONE);
  assign cpu.cpu_rdata  = (cpu_sel == RSEL_OAM) ? oam_dout :
                          (cpu_sel == RSEL_FF)  ? 8'hFF    : 8'h00;
  assign ppu_rvalid     = (ppu_sel != RSEL_NONE);
  assign ppu_rdata      = (ppu_sel == RSEL_OAM) ? oam_dout :
                          (ppu_sel == RSEL_FF)  ? 8'hFF    : 8'h00;

endmodule

// File: tb/tb_oam_access_ctrl.sv
// Bench for oam_access_ctrl: OAM RAM and DMA source bus models, reference
// OAM image, vector table, random CPU/PPU traffic and DMA corner sequences.
module tb_oam_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ppu_mode;
  logic        ppu_req;
  logic [7:0]  ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        ppu_rvalid;
  logic        dma_start;
  logic [7:0]  dma_src_hi;
  logic        dma_bus_req;
  logic [15:0] dma_bus_addr;
  logic [7:0]  dma_bus_rdata;
  logic        dma_active;
  logic        oam_en, oam_we;
  logic [7:0]  oam_addr, oam_din, oam_dout;

  oam_access_ctrl_if cif();

  oam_access_ctrl dut (
    .clk(clk), .reset(reset), .cpu(cif),
    .ppu_mode(ppu_mode), .ppu_req(ppu_req), .ppu_addr(ppu_addr),
    .ppu_rdata(ppu_rdata), .ppu_rvalid(ppu_rvalid),
    .dma_start(dma_start), .dma_src_hi(dma_src_hi),
    .dma_bus_req(dma_bus_req), .dma_bus_addr(dma_bus_addr), .dma_bus_rdata(dma_bus_rdata),
    .dma_active(dma_active),
    .oam_en(oam_en), .oam_we(oam_we), .oam_addr(oam_addr), .oam_din(oam_din),
    .oam_dout(oam_dout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int bad_acc = 0;
  logic [7:0]  ram [256];
  logic [7:0]  ref_oam [160];
  logic [15:0] bus_q [$];

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return 8'(a[7:0] * 8'd7 + a[15:8] + 8'h13);
  endfunction

  // OAM RAM: registered read; garbage on dout when nobody reads.
  always @(posedge clk) begin
    if (oam_en && oam_we) ram[oam_addr] <= oam_din;
    if (oam_en && !oam_we) oam_dout <= ram[oam_addr];
    else                   oam_dout <= 8'($urandom);
    if (oam_en && oam_addr >= 8'd160) bad_acc++;
  end

  // Source bus: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (dma_bus_req) dma_bus_rdata <= src_byte(dma_bus_addr);
    else             dma_bus_rdata <= 8'($urandom);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; cif.cpu_addr = 8'h00; cif.cpu_wdata = 8'h00;
    ppu_req = 1'b0; ppu_addr = 8'h00; ppu_mode = 2'd0;
  endtask

  // Runs from the first cycle after dma_start until dma_active drops.
  task automatic collect(input bit poke, output int act, output int first_rd, output bit ok);
    act = 0; first_rd = -1; ok = 1'b0;
    bus_q.delete();
    for (int k = 0; k < 1000; k++) begin
      cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; ppu_req = 1'b0;
      if (poke && k == 20) begin cif.cpu_req = 1'b1; cif.cpu_addr = 8'h10; end
      if (poke && k == 22) begin
        cif.cpu_req = 1'b1; cif.cpu_we = 1'b1; cif.cpu_addr = 8'h10; cif.cpu_wdata = 8'h55;
      end
      if (poke && k == 24) begin ppu_req = 1'b1; ppu_addr = 8'h04; end
      @(negedge clk);
      if (poke && k == 21) begin
        chk("dma_cpu_rd_rvalid", cif.cpu_rvalid, 1);
        chk("dma_cpu_rd_data", cif.cpu_rdata, 8'hFF);
      end
      if (poke && k == 23) chk("dma_cpu_wr_no_rvalid", cif.cpu_rvalid, 0);
      if (poke && k == 25) begin
        chk("dma_ppu_rvalid", ppu_rvalid, 1);
        chk("dma_ppu_data", ppu_rdata, 8'hFF);
      end
      if (!dma_active) begin ok = 1'b1; break; end
      act++;
      if (dma_bus_req) begin
        if (first_rd < 0) first_rd = k;
        bus_q.push_back(dma_bus_addr);
      end
      @(posedge clk); #1;
    end
    cif.cpu_req = 1'b0; cif.cpu_we = 1'b0; ppu_req = 1'b0;
  endtask

  task automatic chk_bus(input string nm, input logic [7:0] page);
    int nb;
    nb = 0;
    for (int i = 0; i < bus_q.size(); i++)
      if (bus_q[i] !== {page, 8'(i)}) nb++;
    chk({nm, "_count"}, bus_q.size(), 160);
    chk({nm, "_addr"}, nb, 0);
  endtask

  task automatic wait_rd_idx(input logic [7:0] idx, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (dma_bus_req && dma_bus_addr[7:0] == idx) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic start_dma(input logic [7:0] page);
    dma_src_hi = page; dma_start = 1'b1;
    step();
    dma_start = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic       creq;
    logic       cwe;
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic [1:0] mode;
    logic       preq;
    logic [7:0] paddr;
    logic       ecv;
    logic [7:0] ecd;
    logic       epv;
    logic [7:0] epd;
  } vec_t;

  vec_t tv [13];

  initial begin
    int act, first_rd, nb, nreq;
    bit ok;
    logic [7:0] e_cd, e_pd, mpage;
    logic e_cv, e_pv, blocked;

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    idle_inputs();
    reset = 1'b1; dma_start = 1'b0; dma_src_hi = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_dma_active", dma_active, 0);
    chk("rst_dma_bus_req", dma_bus_req, 0);
    chk("rst_dma_bus_addr", dma_bus_addr, 0);
    chk("rst_oam_en", oam_en, 0);
    chk("rst_oam_we", oam_we, 0);
    chk("rst_oam_addr", oam_addr, 0);
    chk("rst_oam_din", oam_din, 0);
    chk("rst_cpu_rvalid", cif.cpu_rvalid, 0);
    chk("rst_cpu_rdata", cif.cpu_rdata, 0);
    chk("rst_ppu_rvalid", ppu_rvalid, 0);
    chk("rst_ppu_rdata", ppu_rdata, 0);

    // Full DMA from C1 with blocked CPU/PPU traffic in the middle.
    dma_src_hi = 8'hC1; dma_start = 1'b1;
    #1 chk("active_not_same_cycle", dma_active, 0);
    step();
    dma_start = 1'b0;
    collect(1'b1, act, first_rd, ok);
    step();
    chk("dma1_done", ok, 1);
    chk("dma1_active_cycles", act, 324);
    chk("dma1_first_rd", first_rd, 4);
    chk_bus("dma1_bus", 8'hC1);
    nb = 0;
    for (int i = 0; i < 160; i++) begin
      ref_oam[i] = src_byte({8'hC1, 8'(i)});
      if (ram[i] !== ref_oam[i]) nb++;
    end
    chk("dma1_oam_image", nb, 0);
    chk("dma1_oam_10_kept", ram[8'h10], src_byte(16'hC110));

    tv[0]  = '{"ppu_beats_cpu_m2", 1, 0, 8'h08, 8'h00, 2'd2, 1, 8'h04, 1, 8'hFF, 1, ref_oam[8'h04]};
    tv[1]  = '{"cpu_rd_m0",        1, 0, 8'h08, 8'h00, 2'd0, 0, 8'h00, 1, ref_oam[8'h08], 0, 8'h00};
    tv[2]  = '{"cpu_wr_unusable",  1, 1, 8'hA0, 8'h12, 2'd0, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    tv[3]  = '{"cpu_rd_unusable",  1, 0, 8'hA5, 8'h00, 2'd0, 0, 8'h00, 1, 8'h00, 0, 8'h00};
    tv[4]  = '{"cpu_rd_m3",        1, 0, 8'h20, 8'h00, 2'd3, 0, 8'h00, 1, 8'hFF, 0, 8'h00};
    tv[5]  = '{"cpu_rd_m1",        1, 0, 8'h20, 8'h00, 2'd1, 0, 8'h00, 1, ref_oam[8'h20], 0, 8'h00};
    tv[6]  = '{"ppu_beats_cpu_m0", 1, 0, 8'h03, 8'h00, 2'd0, 1, 8'h9F, 1, 8'hFF, 1, ref_oam[8'h9F]};
    tv[7]  = '{"cpu_wr_30",        1, 1, 8'h30, 8'hA7, 2'd0, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    tv[8]  = '{"cpu_rd_30",        1, 0, 8'h30, 8'h00, 2'd1, 0, 8'h00, 1, 8'hA7, 0, 8'h00};
    tv[9]  = '{"cpu_wr_m2_drop",   1, 1, 8'h31, 8'h11, 2'd2, 0, 8'h00, 0, 8'h00, 0, 8'h00};
    tv[10] = '{"cpu_rd_31",        1, 0, 8'h31, 8'h00, 2'd0, 0, 8'h00, 1, ref_oam[8'h31], 0, 8'h00};
    tv[11] = '{"ppu_only_m3",      0, 0, 8'h00, 8'h00, 2'd3, 1, 8'h00, 0, 8'h00, 1, ref_oam[8'h00]};
    tv[12] = '{"idle",             0, 0, 8'h00, 8'h00, 2'd0, 0, 8'h00, 0, 8'h00, 0, 8'h00};

    for (int i = 0; i < 13; i++) begin
      cif.cpu_req = tv[i].creq; cif.cpu_we = tv[i].cwe;
      cif.cpu_addr = tv[i].caddr; cif.cpu_wdata = tv[i].cwd;
      ppu_mode = tv[i].mode; ppu_req = tv[i].preq; ppu_addr = tv[i].paddr;
      step();
      idle_inputs();
      chk({tv[i].name, "_cpu_rvalid"}, cif.cpu_rvalid, tv[i].ecv);
      if (tv[i].ecv) chk({tv[i].name, "_cpu_rdata"}, cif.cpu_rdata, tv[i].ecd);
      chk({tv[i].name, "_ppu_rvalid"}, ppu_rvalid, tv[i].epv);
      if (tv[i].epv) chk({tv[i].name, "_ppu_rdata"}, ppu_rdata, tv[i].epd);
    end
    ref_oam[8'h30] = 8'hA7;

    // Random CPU/PPU traffic with DMA idle, against the reference OAM image.
    for (int n = 0; n < 400; n++) begin
      cif.cpu_req   = ($urandom_range(0, 1) == 1);
      cif.cpu_we    = ($urandom_range(0, 2) == 0);
      cif.cpu_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
      cif.cpu_wdata = 8'($urandom);
      ppu_mode      = 2'($urandom_range(0, 3));
      ppu_req       = ($urandom_range(0, 2) == 0);
      ppu_addr      = 8'($urandom_range(0, 159));
      blocked = (ppu_mode >= 2) || ppu_req;
      e_cv = cif.cpu_req && !cif.cpu_we;
      e_cd = blocked ? 8'hFF : (cif.cpu_addr >= 160) ? 8'h00 : ref_oam[cif.cpu_addr];
      e_pv = ppu_req;
      e_pd = ref_oam[ppu_addr];
      if (cif.cpu_req && cif.cpu_we && !blocked && cif.cpu_addr < 160)
        ref_oam[cif.cpu_addr] = cif.cpu_wdata;
      step();
      chk("rnd_cpu_rvalid", cif.cpu_rvalid, e_cv);
      if (e_cv) chk("rnd_cpu_rdata", cif.cpu_rdata, e_cd);
      chk("rnd_ppu_rvalid", ppu_rvalid, e_pv);
      if (e_pv) chk("rnd_ppu_rdata", ppu_rdata, e_pd);
    end
    idle_inputs();
    step();
    nb = 0;
    for (int i = 0; i < 160; i++) if (ram[i] !== ref_oam[i]) nb++;
    chk("rnd_oam_image", nb, 0);

    // Restart at idx 50 with a new source page.
    start_dma(8'h3A);
    wait_rd_idx(8'd50, ok);
    chk("restart_wait", ok, 1);
    start_dma(8'hD0);
    collect(1'b0, act, first_rd, ok);
    step();
    chk("restart_done", ok, 1);
    chk("restart_active_cycles", act, 324);
    chk("restart_first_rd", first_rd, 4);
    chk_bus("restart_bus", 8'hD0);
    nb = 0;
    for (int i = 0; i < 160; i++) if (ram[i] !== src_byte({8'hD0, 8'(i)})) nb++;
    chk("restart_oam_image", nb, 0);

    // Reset during the write of idx 80.
    start_dma(8'h77);
    wait_rd_idx(8'd80, ok);
    chk("reset_wait", ok, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid_active", dma_active, 0);
    nreq = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dma_bus_req || oam_en) nreq++;
    end
    step();
    chk("reset_mid_quiet", nreq, 0);
    nb = 0;
    for (int i = 0; i < 160; i++)
      if (ram[i] !== src_byte({(i < 80) ? 8'h77 : 8'hD0, 8'(i)})) nb++;
    chk("reset_mid_oam_image", nb, 0);

    // Echo page source.
`ifdef OAM_DMA_ECHO_MIRROR_EN
    mpage = 8'hC3;
`else
    mpage = 8'hE3;
`endif
    start_dma(8'hE3);
    collect(1'b0, act, first_rd, ok);
    step();
    chk("mirror_done", ok, 1);
    chk_bus("mirror_bus", mpage);
    nb = 0;
    for (int i = 0; i < 160; i++) if (ram[i] !== src_byte({mpage, 8'(i)})) nb++;
    chk("mirror_oam_image", nb, 0);

    chk("oam_addr_in_range", bad_acc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
